// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy game core (physics controller and AI pilot).
package flappy_pkg;

  localparam int unsigned GROUND_Y    = 668;
  localparam int unsigned BIRD_HEIGHT = 35;
  // 65 MHz / 60 Hz terminal count; frame period is FRAME_DIV+1 cycles.
  localparam int unsigned FRAME_DIV   = 1083333;

  // Width of the signed per-frame velocity estimate.
  localparam int unsigned VEL_W = 10;

  typedef enum logic [2:0] {
    AI_IDLE     = 3'd0,
    AI_TRACK    = 3'd1,
    AI_DECIDE   = 3'd2,
    AI_FIRE     = 3'd3,
    AI_COOLDOWN = 3'd4
  } ai_state_e;

  // Saturate a 13-bit signed pixel difference into the VEL_W-bit range [-512, 511].
  function automatic logic [VEL_W-1:0] sat10(input logic signed [12:0] d);
    logic [VEL_W-1:0] r;
    if (d > 13'sd511) begin
      r = 10'b01_1111_1111;
    end else if (d < -13'sd512) begin
      r = 10'b10_0000_0000;
    end else begin
      r = d[VEL_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter: counts 0..FRAME_DIV and pulses frame_tick while at FRAME_DIV.
module frame_tick_gen #(
  parameter int unsigned FRAME_DIV = flappy_pkg::FRAME_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int unsigned CW = (FRAME_DIV < 1) ? 1 : $clog2(FRAME_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(FRAME_DIV);

  logic [CW-1:0] cnt_q;

  // Counter wraps to zero on the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign frame_tick = (cnt_q == TERM);

endmodule

// File: rtl/flappy_ai_pilot.sv
// Autopilot for the bird: estimates velocity once per frame, predicts the next position and
// issues a one-cycle ai_jump when the bird would sink below the aim line.
// Optional macro AI_JITTER_EN: subtracts 0..15 px of LFSR jitter from the aim line.
module flappy_ai_pilot #(
  parameter int unsigned FRAME_DIV       = flappy_pkg::FRAME_DIV,
  parameter int unsigned BIRD_HEIGHT     = flappy_pkg::BIRD_HEIGHT,
  parameter int unsigned GAP_H           = 160,
  parameter int unsigned AIM_MARGIN      = 12,
  parameter int unsigned CEIL_GUARD      = 40,
  parameter int unsigned COOLDOWN_FRAMES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_active,
  input  logic        auto_mode,
  input  logic [11:0] bird_y,
  input  logic [11:0] gap_top,
  output logic        ai_jump,
  output logic [9:0]  vel_est,
  output logic [2:0]  ai_state
);

  import flappy_pkg::*;

  localparam logic signed [13:0] BH_S      = 14'(BIRD_HEIGHT);
  localparam logic signed [13:0] TGT_OFS   = 14'(GAP_H - AIM_MARGIN);
  localparam logic [11:0]        CEIL_Y    = 12'(CEIL_GUARD);
  localparam logic [3:0]         COOL_INIT = 4'(COOLDOWN_FRAMES);

  ai_state_e         state_q, state_d;
  logic [11:0]       y_prev_q, y_prev_d;
  logic [VEL_W-1:0]  vel_q, vel_d;
  logic              vel_valid_q, vel_valid_d;
  logic [3:0]        cool_q, cool_d;
  logic              jump_q, jump_d;

  logic              frame_tick;
  logic              enable;
  logic              sample_en;
  logic signed [12:0] y_diff;
  logic signed [13:0] pred;
  logic signed [13:0] target;

  frame_tick_gen #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign enable = game_active & auto_mode;

`ifdef AI_JITTER_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR (taps 16,14,13,11) stepping once per frame for aim-line jitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (frame_tick) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end
`endif

  // Prediction and aim line, all in signed 14-bit so a strongly negative velocity stays sane.
  always_comb begin
    y_diff = $signed({1'b0, bird_y}) - $signed({1'b0, y_prev_q});
    pred   = $signed({2'b00, bird_y}) + $signed({{4{vel_q[VEL_W-1]}}, vel_q}) + BH_S;
`ifdef AI_JITTER_EN
    target = $signed({2'b00, gap_top}) + TGT_OFS - $signed({10'd0, lfsr_q[3:0]});
`else
    target = $signed({2'b00, gap_top}) + TGT_OFS;
`endif
  end

  // Next-state logic; dropping enable overrides everything, even mid-FIRE.
  always_comb begin
    state_d     = state_q;
    y_prev_d    = y_prev_q;
    vel_d       = vel_q;
    vel_valid_d = vel_valid_q;
    cool_d      = cool_q;
    jump_d      = 1'b0;
    sample_en   = 1'b0;

    if (!enable) begin
      state_d     = AI_IDLE;
      vel_valid_d = 1'b0;
      cool_d      = '0;
      vel_d       = '0;
    end else begin
      case (state_q)
        AI_IDLE: state_d = AI_TRACK;
        AI_TRACK: begin
          if (frame_tick) begin
            sample_en = 1'b1;
            state_d   = AI_DECIDE;
          end
        end
        AI_DECIDE: begin
          if ((pred > target) && (bird_y >= CEIL_Y)) begin
            state_d = AI_FIRE;
            jump_d  = 1'b1;
          end else begin
            state_d = AI_TRACK;
          end
        end
        AI_FIRE: begin
          cool_d  = COOL_INIT;
          state_d = AI_COOLDOWN;
        end
        AI_COOLDOWN: begin
          if (frame_tick) begin
            sample_en = 1'b1;
            cool_d    = cool_q - 4'd1;
            if (cool_q <= 4'd1) begin
              cool_d  = '0;
              state_d = AI_TRACK;
            end
          end
        end
        default: state_d = AI_IDLE;
      endcase

      // First sample after (re)entry only primes y_prev; velocity needs two samples.
      if (sample_en) begin
        y_prev_d = bird_y;
        if (vel_valid_q) begin
          vel_d = sat10(y_diff);
        end else begin
          vel_d       = '0;
          vel_valid_d = 1'b1;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= AI_IDLE;
      y_prev_q    <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
      cool_q      <= '0;
      jump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_prev_q    <= y_prev_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
      cool_q      <= cool_d;
      jump_q      <= jump_d;
    end
  end

  assign ai_jump  = jump_q;
  assign vel_est  = vel_q;
  assign ai_state = state_q;

endmodule

// File: tb/tb_flappy_ai_pilot.sv
// Bench for flappy_ai_pilot with a short frame (FRAME_DIV=9): an event-level model of the
// pilot checked every cycle, plus hand-computed literal expectations on key cycles.
module tb_flappy_ai_pilot;

  localparam int FDIV   = 9;
  localparam int BIRD_H = 35;
  localparam int GAP    = 160;
  localparam int MARGIN = 12;
  localparam int CEIL   = 40;
  localparam int COOL   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        game_active = 1'b0;
  logic        auto_mode = 1'b0;
  logic [11:0] bird_y = '0;
  logic [11:0] gap_top = '0;
  logic        ai_jump;
  logic [9:0]  vel_est;
  logic [2:0]  ai_state;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  flappy_ai_pilot #(
    .FRAME_DIV       (FDIV),
    .BIRD_HEIGHT     (BIRD_H),
    .GAP_H           (GAP),
    .AIM_MARGIN      (MARGIN),
    .CEIL_GUARD      (CEIL),
    .COOLDOWN_FRAMES (COOL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_active (game_active),
    .auto_mode   (auto_mode),
    .bird_y      (bird_y),
    .gap_top     (gap_top),
    .ai_jump     (ai_jump),
    .vel_est     (vel_est),
    .ai_state    (ai_state)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int m_phase = 0;     // position inside the current frame
  int m_vel = 0;
  int m_y_prev = 0;
  int m_cool = 0;      // ticks still to skip after a jump
  bit m_run = 0;       // pilot has left idle
  bit m_valid = 0;
  bit m_decide = 0;    // a decision is due at the next edge
  bit m_exp_jump = 0;
  bit m_tick_edge = 0;
`ifdef AI_JITTER_EN
  logic [15:0] m_lfsr = 16'hACE1;
`endif

  function automatic int sat(input int d);
    if (d > 511) return 511;
    if (d < -512) return -512;
    return d;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_vel = 0; m_y_prev = 0; m_cool = 0;
    m_run = 0; m_valid = 0; m_decide = 0; m_exp_jump = 0; m_tick_edge = 0;
`ifdef AI_JITTER_EN
    m_lfsr = 16'hACE1;
`endif
  endtask

  task automatic model_step();
    bit en;
    bit tick;
    int pred;
    int target;
    int jit;
    en = game_active && auto_mode;
    tick = (m_phase == FDIV);
    m_phase = tick ? 0 : m_phase + 1;
    m_tick_edge = tick;
    jit = 0;
`ifdef AI_JITTER_EN
    if (tick) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    jit = int'(m_lfsr[3:0]);
`endif
    m_exp_jump = 0;
    if (!en) begin
      m_run = 0; m_valid = 0; m_cool = 0; m_vel = 0; m_decide = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (m_decide) begin
      m_decide = 0;
      pred = int'(bird_y) + m_vel + BIRD_H;
      target = int'(gap_top) + GAP - MARGIN - jit;
      if (pred > target && int'(bird_y) >= CEIL) begin
        m_exp_jump = 1;
        m_cool = COOL;
      end
    end else if (tick) begin
      if (m_valid) m_vel = sat(int'(bird_y) - m_y_prev);
      else begin
        m_vel = 0;
        m_valid = 1;
      end
      m_y_prev = int'(bird_y);
      if (m_cool > 0) m_cool--;
      else m_decide = 1;
    end
  endtask

  function automatic int exp_state();
    if (!m_run) return 0;
    if (m_decide) return 2;
    if (m_exp_jump) return 3;
    if (m_cool > 0) return 4;
    return 1;
  endfunction

  always @(negedge rst_n) model_reset();

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin
    wait (chk_on);
    forever begin
      @(negedge clk);
      chk("cyc_jump", int'(ai_jump), int'(m_exp_jump));
      chk("cyc_vel", int'($signed(vel_est)), m_vel);
      chk("cyc_state", int'(ai_state), exp_state());
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_tick_edge && n < 4 * (FDIV + 1));
    if (!m_tick_edge) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout at %0t: got no frame tick expected one", $time);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_jump", int'(ai_jump), 0);
    chk("rst_state", int'(ai_state), 0);
    chk("rst_vel", int'($signed(vel_est)), 0);
    chk_on = 1'b1;
    game_active = 1'b1;
    auto_mode = 1'b1;
    bird_y = 12'd300;
    gap_top = 12'd200;
    step();
    step();
    rst_n = 1'b1;

    // First tick primes velocity; pred 335 <= 348, no jump.
    wait_tick();
    chk("first_vel", int'($signed(vel_est)), 0);
    chk("first_state", int'(ai_state), 2);
    step();
    chk("first_nojump", int'(ai_jump), 0);
    chk("first_back_track", int'(ai_state), 1);

    // bird_y 316: vel 16, pred 367 > 348 -> jump two cycles after the tick.
    bird_y = 12'd316;
    wait_tick();
    chk("b_vel16", int'($signed(vel_est)), 16);
    chk("b_decide_nojump", int'(ai_jump), 0);
    step();
    chk("b_jump", int'(ai_jump), 1);
    chk("b_fire_state", int'(ai_state), 3);
    step();
    chk("b_jump_one_cycle", int'(ai_jump), 0);
    chk("b_cooldown", int'(ai_state), 4);

    // Sinking further during cooldown: no jump for 6 ticks, then jump on the 7th.
    for (int k = 1; k <= 6; k++) begin
      bird_y = 12'(316 + 10 * k);
      wait_tick();
      chk("cool_vel", int'($signed(vel_est)), 10);
      chk("cool_state", int'(ai_state), (k == 6) ? 1 : 4);
      step();
      chk("cool_nojump", int'(ai_jump), 0);
    end
    bird_y = 12'd386;
    wait_tick();
    chk("c_decide", int'(ai_state), 2);
    step();
    chk("c_second_jump", int'(ai_jump), 1);
    step();

    // Drop auto_mode during cooldown, then re-enter: velocity estimation restarts.
    wait_tick();
    wait_tick();
    chk("d_still_cool", int'(ai_state), 4);
    step();
    step();
    step();
    auto_mode = 1'b0;
    step();
    chk("d_idle", int'(ai_state), 0);
    chk("d_vel_clr", int'($signed(vel_est)), 0);
    chk("d_jump_clr", int'(ai_jump), 0);
    step();
    step();
    step();
    bird_y = 12'd0;
    gap_top = 12'd0;
    auto_mode = 1'b1;
    wait_tick();
    chk("d_reentry_vel0", int'($signed(vel_est)), 0);
    step();
    chk("d_reentry_nojump", int'(ai_jump), 0);

    // 0 -> 600: saturate to +511; bird_y 30 at decision trips the ceiling guard.
    bird_y = 12'd600;
    wait_tick();
    chk("e_sat_pos", int'($signed(vel_est)), 511);
    bird_y = 12'd30;
    step();
    chk("e_ceil_nojump", int'(ai_jump), 0);
    chk("e_ceil_state", int'(ai_state), 1);

    // 600 -> 0: saturate to -512.
    bird_y = 12'd0;
    wait_tick();
    chk("f_sat_neg", int'($signed(vel_est)), -512);
    step();
    chk("f_nojump", int'(ai_jump), 0);

    // Jump again, then assert reset while ai_jump is high.
    bird_y = 12'd300;
    wait_tick();
    chk("g_vel300", int'($signed(vel_est)), 300);
    step();
    chk("g_jump", int'(ai_jump), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("g_rst_jump", int'(ai_jump), 0);
    chk("g_rst_state", int'(ai_state), 0);
    chk("g_rst_vel", int'($signed(vel_est)), 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flappy_ai_pilot.md
Name: flappy_ai_pilot

Overview:
- Autopilot that generates the `ai_jump` pulse consumed by the bird physics controller in auto mode. It is the initiator end of the jump interface.
- Runs its own 60 Hz frame tick. Each frame it estimates bird velocity from successive `bird_y` samples, predicts the next position against the current pipe gap, and fires a single-cycle jump when the bird would sink below the target line.
- Sits beside the physics controller in the game core and shares the 65 MHz HDMI clock domain.

Parameters:
- FRAME_DIV, 1083333, terminal count of frame counter (65 MHz / 60 Hz); tick period = FRAME_DIV+1 cycles
- BIRD_HEIGHT, 35, bird sprite height in pixels
- GAP_H, 160, vertical pipe gap height in pixels
- AIM_MARGIN, 12, pixels kept between bird bottom and gap bottom
- CEIL_GUARD, 40, no jump while bird_y < CEIL_GUARD
- COOLDOWN_FRAMES, 6, minimum frame ticks between jumps (range 1..15)

Ports:
- clk  in  1  65 MHz pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- game_active  in  1  game running
- auto_mode  in  1  1 = AI controls bird
- bird_y  in  12  current bird top Y, unsigned
- gap_top  in  12  Y of top edge of the gap of the nearest unpassed pipe
- ai_jump  out  1  registered single-cycle jump request
- vel_est  out  10  signed velocity estimate, pixels/frame (debug)
- ai_state  out  3  FSM state encoding (debug)

Behaviour:
- Reset (async, rst_n low): ai_jump=0, vel_est=0, ai_state=IDLE, frame counter=0, cooldown=0, y_prev=0, vel_valid=0.
- Frame counter:
  - counts 0..FRAME_DIV, then wraps to 0.
  - frame_tick=1 for exactly one cycle when count==FRAME_DIV.
  - runs regardless of game_active.
- enable = game_active & auto_mode. Whenever enable=0: the next edge forces IDLE, ai_jump=0, vel_valid=0, cooldown=0, vel_est=0. This holds in every state, including mid-FIRE.
- States: IDLE=0, TRACK=1, DECIDE=2, FIRE=3, COOLDOWN=4.
  - IDLE: when enable=1 → TRACK.
  - TRACK: on frame_tick, sample y_prev<=bird_y.
    - If vel_valid=1, vel_est<=sat10(bird_y - y_prev), saturating to [-512,511]; otherwise vel_est<=0 and vel_valid<=1.
    - → DECIDE.
  - DECIDE (1 cycle): compute in signed 14-bit.
    - pred = bird_y + vel_est + BIRD_HEIGHT
    - target = gap_top + GAP_H - AIM_MARGIN
    - If pred > target and bird_y >= CEIL_GUARD → FIRE; else → TRACK.
    - Comparison is strictly greater; pred == target does not fire.
  - FIRE (1 cycle): ai_jump=1 this cycle only; load cooldown=COOLDOWN_FRAMES; → COOLDOWN.
  - COOLDOWN: on each frame_tick, still sample y_prev/vel_est as in TRACK and decrement cooldown; when it reaches 0 → TRACK. No jump is possible while in COOLDOWN.
- Latency: ai_jump rises exactly 2 cycles after the frame_tick cycle (tick → DECIDE → FIRE). This is far from the physics update, so the physics controller sees the jump before its next frame update.
- ai_jump is never high for 2 consecutive cycles. Minimum spacing between jumps = COOLDOWN_FRAMES+1 ticks.
- gap_top changing mid-frame is fine: it is sampled only in DECIDE.
- bird_y is treated as stable; no synchronizer (same clock domain).
- Deasserting enable and reasserting it restarts velocity estimation: the first tick after re-entry gives vel_est=0.

Optional Feature:
- Macro AI_JITTER_EN.
- When defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every frame_tick;
  - target in DECIDE becomes gap_top + GAP_H - AIM_MARGIN - lfsr[3:0], giving 0..15 px jitter so the AI looks less robotic.
- When undefined: no LFSR, and target is exactly as specified above.

Decomposition:
- Shared package flappy_pkg:
  - FSM state localparams (AI_IDLE..AI_COOLDOWN);
  - GROUND_Y=668, BIRD_HEIGHT=35, FRAME_DIV=1083333 so the physics controller and the pilot agree;
  - the sat10 width constant.
- One sub-module is natural: frame_tick_gen (parameter FRAME_DIV; clk, rst_n → frame_tick). It is reusable by the physics block.
- LFSR stays inline.

Test Plan (FRAME_DIV=9 for simulation):
- Reset mid-FIRE: assert rst_n=0 while ai_jump=1 → ai_jump=0 immediately (async), ai_state=0, vel_est=0.
- enable=1, bird_y=300, gap_top=200, first tick → vel_est=0; pred=335 ≤ 348 → no jump, state returns to TRACK.
- Next tick with bird_y=316:
  - vel_est=16, pred=367 > 348 → ai_jump high exactly 2 cycles after the tick, 1 cycle wide;
  - no further jump for 6 ticks even though bird_y keeps rising toward target.
- bird_y=30 (< CEIL_GUARD), gap_top=0 → pred exceeds target but ai_jump stays 0.
- Velocity saturation: bird_y 0 then 600 across two ticks → vel_est=511; 600 then 0 → vel_est=-512.
- auto_mode dropped during COOLDOWN → next edge ai_state=IDLE, cooldown cleared. Reassert → first decision uses vel_est=0.
- (AI_JITTER_EN) tick count N vs reference LFSR model → target matches gap_top+148-lfsr[3:0] each decision.
